// File: rtl/zout_store_arb.sv
// Round-robin arbiter that shares one PSU store path and TAPU index sequencer between NUM_REQ cores.
// Optional perf counters are enabled with `define ZOUT_STORE_ARB_PERF_EN.
module zout_store_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DEPTH_W    = 7,
  parameter int TAPU_W     = 4,
  parameter int IDX_W      = 3,
  parameter int GAP_CYCLES = 1,
  localparam int SEL_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*DEPTH_W-1:0] req_store_depth,
  input  logic [NUM_REQ*TAPU_W-1:0]  req_tapu_depth,
  output logic [NUM_REQ-1:0]         req_done,
  output logic                       psu_store_en,
  output logic [SEL_W-1:0]           psu_store_sel,
`ifdef ZOUT_STORE_ARB_PERF_EN
  output logic [31:0]                perf_store_beats,
  output logic [31:0]                perf_wait_cycles,
`endif
  output logic [IDX_W-1:0]           tapu_store_idx,
  output logic                       store_last,
  output logic                       busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] STORE = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  logic [1:0]         state;
  logic [SEL_W-1:0]   ptr, sel, grant_idx, ptr_next;
  logic               grant_found, accept, beat_last;
  logic [NUM_REQ-1:0] rot_valid;
  logic [DEPTH_W-1:0] depth_r, beat_cnt, grant_depth;
  logic [TAPU_W-1:0]  tapu_depth_r, tapu_cnt, grant_tapu;
  logic [IDX_W-1:0]   idx;
  logic [3:0]         gap_cnt;
  int                 pos;

  // Rotate the request vector so bit 0 is the pointer, then take the first set bit.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    pos         = 0;
    rot_valid   = NUM_REQ'({req_valid, req_valid} >> ptr);
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!grant_found && rot_valid[j]) begin
        grant_found = 1'b1;
        pos         = int'(ptr) + j;
        if (pos >= NUM_REQ) pos = pos - NUM_REQ;
        grant_idx   = SEL_W'(pos);
      end
    end
  end

  always_comb begin
    grant_depth = '0;
    grant_tapu  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == SEL_W'(i)) begin
        grant_depth = req_store_depth[i*DEPTH_W +: DEPTH_W];
        grant_tapu  = req_tapu_depth[i*TAPU_W +: TAPU_W];
      end
    end
  end

  // A grant during the reset cycle would be lost, so it is suppressed.
  assign accept    = (state == IDLE) && grant_found && !rst;
  assign ptr_next  = (grant_idx == SEL_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  assign beat_last = (state == STORE) && (beat_cnt == depth_r);

  assign req_ready      = accept ? (NUM_REQ'(1) << grant_idx) : '0;
  assign req_done       = beat_last ? (NUM_REQ'(1) << sel) : '0;
  assign psu_store_en   = (state == STORE);
  assign psu_store_sel  = sel;
  assign tapu_store_idx = idx;
  assign store_last     = beat_last;
  assign busy           = (state == STORE) || (state == GAP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      sel          <= '0;
      depth_r      <= '0;
      tapu_depth_r <= '0;
      beat_cnt     <= '0;
      tapu_cnt     <= '0;
      idx          <= '0;
      gap_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state        <= STORE;
            sel          <= grant_idx;
            ptr          <= ptr_next;
            depth_r      <= grant_depth;
            tapu_depth_r <= grant_tapu;
            beat_cnt     <= '0;
            tapu_cnt     <= '0;
            idx          <= '0;
          end
        end
        STORE: begin
          beat_cnt <= beat_cnt + 1'b1;
          // The index advances on the beat after the TAPU counter wraps.
          if (tapu_cnt == tapu_depth_r) begin
            tapu_cnt <= '0;
            idx      <= idx + 1'b1;
          end else begin
            tapu_cnt <= tapu_cnt + 1'b1;
          end
          if (beat_last) begin
            state   <= (GAP_CYCLES > 0) ? GAP : IDLE;
            gap_cnt <= '0;
          end
        end
        GAP: begin
          if (gap_cnt == 4'(GAP_CYCLES - 1)) state <= IDLE;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ZOUT_STORE_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_store_beats <= '0;
      perf_wait_cycles <= '0;
    end else begin
      if (psu_store_en && (perf_store_beats != '1))
        perf_store_beats <= perf_store_beats + 1'b1;
      if ((|req_valid) && !(|req_ready) && (perf_wait_cycles != '1))
        perf_wait_cycles <= perf_wait_cycles + 1'b1;
    end
  end
`endif

endmodule
